// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Generates stage enables/flushes, EX forwarding selects, the data-memory
// request handshake (with timeout) and stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwen,
  input  logic             mem_access,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwen,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic timeout, freeze, branch_flush, load_use;

  // Hazard classification; a timed-out wait behaves like an acked cycle.
  always_comb begin
    timeout      = (state_q == StMemWait) && !dmem_ack && (wait_q == TimeoutVal);
    freeze       = (state_q == StRun) ? (mem_access && !dmem_ack) : (!dmem_ack && !timeout);
    branch_flush = !freeze && ex_branch_taken;
    // A taken branch squashes the wrong-path ID instruction, so no load-use stall.
    load_use     = !freeze && !ex_branch_taken && ex_is_load && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Stage enables/flushes: freeze > branch flush > load-use stall.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = (state_q == StMemWait) || mem_access;
    mem_err      = timeout;
    if (freeze) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (branch_flush) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Forwarding selects: MEM beats WB, x0 never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_regwen && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
      fwd_a = 2'b10;
    end else if (wb_regwen && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
      fwd_a = 2'b01;
    end
    if (mem_regwen && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
      fwd_b = 2'b10;
    end else if (wb_regwen && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
      fwd_b = 2'b01;
    end
  end

  // Next state, wait counter and performance counters.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_d = stall_q;
    flush_d = flush_q;
    unique case (state_q)
      StRun: begin
        if (mem_access && !dmem_ack) begin
          state_d = StMemWait;
          wait_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (dmem_ack || timeout) begin
          state_d = StRun;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
    if (!pc_en) stall_d = stall_q + CNT_W'(1);
    if (branch_flush) flush_d = flush_q + CNT_W'(1);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a behavioural model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pipeline_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
  logic mem_regwen, mem_access, wb_regwen, dmem_ack;
  logic dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_regwen(mem_regwen),
    .mem_access(mem_access), .wb_rd(wb_rd), .wb_regwen(wb_regwen), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: an outstanding access and how many wait cycles it has spent.
  bit            m_busy   = 1'b0;
  int unsigned   m_waited = 0;
  logic [CW-1:0] m_stall  = '0;
  logic [CW-1:0] m_flush  = '0;

  logic e_timeout, e_freeze, e_branch, e_lu, e_stall;

  function automatic logic [1:0] src(input logic [4:0] rs);
    if (mem_regwen && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwen && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    e_timeout = m_busy && !dmem_ack && (m_waited == TO);
    e_freeze  = m_busy ? (!dmem_ack && !e_timeout) : (mem_access && !dmem_ack);
    e_branch  = !e_freeze && ex_branch_taken;
    e_lu      = !e_freeze && !ex_branch_taken && ex_is_load && ex_rd != 0 &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_stall   = e_freeze || e_lu;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_waited <= 0;
      m_stall  <= '0;
      m_flush  <= '0;
    end else begin
      if (e_stall) m_stall <= m_stall + 1;
      if (e_branch) m_flush <= m_flush + 1;
      if (!m_busy) begin
        if (mem_access && !dmem_ack) begin
          m_busy   <= 1'b1;
          m_waited <= 1;
        end
      end else if (dmem_ack || e_timeout) begin
        m_busy <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("dmem_req", dmem_req, m_busy || mem_access);
      chk("pc_en", pc_en, !e_stall);
      chk("if_id_en", if_id_en, !e_stall);
      chk("id_ex_en", id_ex_en, !e_freeze);
      chk("ex_mem_en", ex_mem_en, !e_freeze);
      chk("mem_wb_en", mem_wb_en, 1'b1);
      chk("if_id_flush", if_id_flush, e_branch);
      chk("id_ex_flush", id_ex_flush, e_branch || e_lu);
      chk("mem_wb_flush", mem_wb_flush, e_freeze);
      chk("mem_err", mem_err, e_timeout);
      chk("fwd_a", fwd_a, src(ex_rs1));
      chk("fwd_b", fwd_b, src(ex_rs2));
      chk("stall_count", stall_count, m_stall);
      chk("flush_count", flush_count, m_flush);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken} = '0;
    {mem_regwen, mem_access, wb_regwen, dmem_ack} = '0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1;
    ex_rd      = 5'd5;
    id_rs1     = 5'd5;
    id_use_rs1 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_req", dmem_req, 0);

    // Load-use stall for one cycle.
    next(); set_load_use();
    @(negedge clk);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_ex_mem_en", ex_mem_en, 1);
    next(); clear_inputs();
    @(negedge clk);
    chk("lu_stall_count", stall_count, 1);

    // Loads to x0 never stall.
    next(); ex_is_load = 1'b1; id_use_rs1 = 1'b1;
    @(negedge clk);
    chk("lu_x0_pc_en", pc_en, 1);

    // Forwarding.
    next(); clear_inputs();
    mem_rd = 5'd3; mem_regwen = 1'b1; wb_rd = 5'd3; wb_regwen = 1'b1;
    ex_rs1 = 5'd3; ex_rs2 = 5'd3;
    @(negedge clk);
    chk("fwd_mem_a", fwd_a, 2'b10);
    chk("fwd_mem_b", fwd_b, 2'b10);
    next(); mem_regwen = 1'b0;
    @(negedge clk);
    chk("fwd_wb_a", fwd_a, 2'b01);
    chk("fwd_wb_b", fwd_b, 2'b01);
    next(); mem_regwen = 1'b1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    @(negedge clk);
    chk("fwd_x0_a", fwd_a, 2'b00);
    chk("fwd_x0_b", fwd_b, 2'b00);
    next(); mem_rd = 5'd7; wb_rd = 5'd9; ex_rs1 = 5'd9; ex_rs2 = 5'd7;
    @(negedge clk);
    chk("fwd_mix_a", fwd_a, 2'b01);
    chk("fwd_mix_b", fwd_b, 2'b10);

    // Branch coinciding with load-use: flush, no stall.
    next(); clear_inputs(); set_load_use(); ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    chk("br_pc_en", pc_en, 1);
    next(); clear_inputs();
    @(negedge clk);
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 1);

    // Memory wait: three cycles without ack, then ack.
    for (int i = 0; i < 4; i++) begin
      next(); mem_access = 1'b1; dmem_ack = (i == 3);
      @(negedge clk);
      chk("mw_req", dmem_req, 1);
      chk("mw_pc_en", pc_en, i == 3);
      chk("mw_wb_flush", mem_wb_flush, i != 3);
    end
    next(); clear_inputs();
    @(negedge clk);
    chk("mw_back_to_run", dmem_req, 0);
    chk("mw_stall_count", stall_count, 4);

    // Timeout: trigger then four wait cycles with ack low; branch held in freeze.
    next(); mem_access = 1'b1;
    @(negedge clk);
    chk("to_trig_err", mem_err, 0);
    for (int i = 1; i <= 4; i++) begin
      next(); mem_access = 1'b0; ex_branch_taken = (i == 2);
      @(negedge clk);
      chk("to_req", dmem_req, 1);
      chk("to_err", mem_err, i == 4);
      chk("to_pc_en", pc_en, i == 4);
      chk("to_if_id_flush", if_id_flush, 0);
    end
    next(); clear_inputs();
    @(negedge clk);
    chk("to_run_req", dmem_req, 0);
    chk("to_err_after", mem_err, 0);
    chk("to_stall_count", stall_count, 8);

    // Reset while waiting with counters nonzero.
    next(); mem_access = 1'b1;
    next(); mem_access = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rr_in_wait", dmem_req, 1);
    next(); rst_n = 1'b1;
    @(negedge clk);
    chk("rr_req", dmem_req, 0);
    chk("rr_stall", stall_count, 0);
    chk("rr_flush", flush_count, 0);
    chk("rr_err", mem_err, 0);
    next(); mem_access = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    chk("rr_zero_wait_req", dmem_req, 1);
    chk("rr_zero_wait_pc", pc_en, 1);
    next(); clear_inputs();
    @(negedge clk);
    chk("rr_zero_wait_stall", stall_count, 0);

    next();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline; consumes register-index and control fields produced by the control decoder at each stage.
- Drives per-stage pipeline register enables and flushes, EX-stage forwarding selects, and the data-memory request handshake.
- Keeps stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, wait cycles without dmem_ack before the access is aborted; legal range 1..255.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous active-low reset
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX
ex_rd  in  5  EX destination register
ex_is_load  in  1  EX holds a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_rd  in  5  MEM destination register
mem_regwen  in  1  MEM instruction writes rd
mem_access  in  1  MEM holds a load or store
wb_rd  in  5  WB destination register
wb_regwen  in  1  WB instruction writes rd
dmem_ack  in  1  data memory completes the access this cycle
dmem_req  out  1  data memory request
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (NOP, regwen=0) into the register
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 MEM result, 01 WB result
mem_err  out  1  one-cycle pulse on memory timeout
stall_count, flush_count  out  CNT_W each  performance counters

Behaviour:
- States: RUN, MEM_WAIT. Reset (rst_n=0 at a clk edge) forces RUN, clears wait counter, stall_count, flush_count and mem_err, from any state including mid-wait.
- Stage outputs are combinational from state and inputs. Default in RUN with no hazard: all enables 1, all flushes 0.
- dmem_req = mem_access in RUN, and 1 throughout MEM_WAIT.
- Zero-wait access: mem_access & dmem_ack in RUN, so no stall and the state stays RUN.
- Memory stall:
  - Trigger: RUN with mem_access & !dmem_ack. Go to MEM_WAIT on the next edge; the wait counter loads 1.
  - Freeze during the trigger cycle and every MEM_WAIT cycle without ack: pc_en, if_id_en, id_ex_en and ex_mem_en are 0, mem_wb_en=1 and mem_wb_flush=1.
  - In MEM_WAIT with dmem_ack: the freeze is lifted in that same cycle (normal RUN outputs), then return to RUN.
  - Wait counter reaches MEM_TIMEOUT with no ack: mem_err=1 for exactly one cycle, the cycle is treated as an acked cycle, then return to RUN.
- Load-use stall: RUN, no memory freeze, ex_is_load & ex_rd!=0, and (id_use_rs1 & id_rs1==ex_rd or id_use_rs2 & id_rs2==ex_rd). Outputs pc_en=0, if_id_en=0, id_ex_flush=1. The remaining enables are 1.
- Branch flush: ex_branch_taken, no memory freeze. Outputs if_id_flush=1, id_ex_flush=1, pc_en=1.
- Priority: memory freeze > branch flush > load-use stall.
  - A branch that coincides with a load-use condition suppresses the stall, because the ID instruction is on the wrong path.
  - A branch that occurs during a freeze is held in the frozen ID/EX register and is acted on once the freeze lifts.
- Forwarding, evaluated independently for a and b:
  - 10 if mem_regwen & mem_rd!=0 & mem_rd==ex_rsX.
  - Otherwise 01 if wb_regwen & wb_rd!=0 & wb_rd==ex_rsX.
  - Otherwise 00. MEM beats WB. x0 is never forwarded.
- Counters:
  - stall_count increments on each cycle with pc_en=0.
  - flush_count increments on each cycle with a branch flush applied.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- Load-use hazard: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_count goes 0->1.
- Forwarding: mem_rd=3, mem_regwen=1, wb_rd=3, wb_regwen=1, ex_rs1=3, ex_rs2=3 -> fwd_a=fwd_b=10. Clear mem_regwen -> 01. Set all rd/rs to 0 -> 00.
- Branch with load-use: ex_branch_taken=1 together with the load-use condition above -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_count=1; stall_count unchanged.
- Memory wait: mem_access=1 with dmem_ack low for 3 cycles, then high -> dmem_req=1 for all 4 cycles; pc_en=0 for 3 cycles; mem_wb_flush=1 for 3 cycles; RUN on the cycle after the ack; stall_count=3.
- Memory timeout: MEM_TIMEOUT=4, dmem_ack held 0 -> mem_err=1 on exactly one cycle (the 4th wait cycle); state returns to RUN; mem_err=0 thereafter.
- Reset mid-operation: rst_n=0 for one edge while in MEM_WAIT with counters nonzero -> RUN, stall_count=0, flush_count=0, mem_err=0; dmem_req follows mem_access on the next cycle.
